// File: rtl/fsm_control_transaccion_pkg.sv
// Shared definitions for the transaction-layer control FSM: state codes,
// FIFO index map and default widths.
package fsm_control_transaccion_pkg;

    // State codes; 5..7 are illegal and recover to reset.
    typedef enum logic [2:0] {
        EstadoReset  = 3'd0,
        EstadoInit   = 3'd1,
        EstadoIdle   = 3'd2,
        EstadoActive = 3'd3,
        EstadoError  = 3'd4
    } estado_e;

    localparam logic [2:0] ESTADO_RESET  = 3'd0;
    localparam logic [2:0] ESTADO_INIT   = 3'd1;
    localparam logic [2:0] ESTADO_IDLE   = 3'd2;
    localparam logic [2:0] ESTADO_ACTIVE = 3'd3;
    localparam logic [2:0] ESTADO_ERROR  = 3'd4;

    // Bit positions inside fifo_empty / fifo_error.
    localparam int unsigned IDX_IN_P0  = 0;
    localparam int unsigned IDX_IN_P1  = 1;
    localparam int unsigned IDX_IN_P2  = 2;
    localparam int unsigned IDX_IN_P3  = 3;
    localparam int unsigned IDX_OUT_P0 = 4;
    localparam int unsigned IDX_OUT_P1 = 5;
    localparam int unsigned IDX_OUT_P2 = 6;
    localparam int unsigned IDX_OUT_P3 = 7;

    localparam int unsigned UMBRAL_WIDTH_DEF = 3;
    localparam int unsigned NUM_FIFOS_DEF    = 8;

endpackage

// File: rtl/fsm_control_transaccion.sv
// Transaction-layer control FSM: sequences reset/config/idle/active/error,
// latches the FIFO thresholds and keeps a sticky per-FIFO error record.
module fsm_control_transaccion
    import fsm_control_transaccion_pkg::*;
#(
    parameter int unsigned UMBRAL_WIDTH = UMBRAL_WIDTH_DEF,
    parameter int unsigned NUM_FIFOS    = NUM_FIFOS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMBRAL_WIDTH-1:0] umbral_alto_in,
    input  logic [UMBRAL_WIDTH-1:0] umbral_bajo_in,
    input  logic [NUM_FIFOS-1:0]    fifo_empty,
    input  logic [NUM_FIFOS-1:0]    fifo_error,
    output logic [UMBRAL_WIDTH-1:0] umbral_alto_out,
    output logic [UMBRAL_WIDTH-1:0] umbral_bajo_out,
    output logic                    arb_enable,
    output logic [2:0]              estado,
    output logic                    idle_out,
    output logic                    active_out,
    output logic                    error_out,
    output logic [NUM_FIFOS-1:0]    error_fifo
);

    estado_e                 state_q, state_d;
    logic [UMBRAL_WIDTH-1:0] umbral_alto_q, umbral_alto_d;
    logic [UMBRAL_WIDTH-1:0] umbral_bajo_q, umbral_bajo_d;
    logic [NUM_FIFOS-1:0]    error_fifo_q, error_fifo_d;

    logic any_error;
    logic all_empty;
    logic config_ok;

    assign any_error = |fifo_error;
    assign all_empty = &fifo_empty;
    assign config_ok = (umbral_bajo_in < umbral_alto_in) && (umbral_alto_in != '0);

    // Next-state logic; priority is fifo_error > init > empty-based.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EstadoReset: state_d = EstadoInit;
            EstadoInit: begin
                if (any_error) begin
                    state_d = EstadoError;
                end else if (!init && config_ok) begin
                    state_d = EstadoIdle;
                end
            end
            EstadoIdle: begin
                if (any_error) begin
                    state_d = EstadoError;
                end else if (init) begin
                    state_d = EstadoInit;
                end else if (!all_empty) begin
                    state_d = EstadoActive;
                end
            end
            EstadoActive: begin
                if (any_error) begin
                    state_d = EstadoError;
                end else if (init) begin
                    state_d = EstadoInit;
                end else if (all_empty) begin
                    state_d = EstadoIdle;
                end
            end
            EstadoError: state_d = EstadoError;
            default:     state_d = EstadoReset;
        endcase
    end

    // Thresholds track the requested values only while configuring.
    always_comb begin
        umbral_alto_d = umbral_alto_q;
        umbral_bajo_d = umbral_bajo_q;
        if (state_q == EstadoInit) begin
            umbral_alto_d = umbral_alto_in;
            umbral_bajo_d = umbral_bajo_in;
        end
    end

    // Sticky error record accumulates in every state except reset.
    always_comb begin
        error_fifo_d = error_fifo_q;
        if (state_q != EstadoReset) begin
            error_fifo_d = error_fifo_q | fifo_error;
        end
    end

    // State, threshold and error registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= EstadoReset;
            umbral_alto_q <= '0;
            umbral_bajo_q <= '0;
            error_fifo_q  <= '0;
        end else begin
            state_q       <= state_d;
            umbral_alto_q <= umbral_alto_d;
            umbral_bajo_q <= umbral_bajo_d;
            error_fifo_q  <= error_fifo_d;
        end
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        estado          = state_q;
        idle_out        = (state_q == EstadoIdle);
        active_out      = (state_q == EstadoActive);
        error_out       = (state_q == EstadoError);
        arb_enable      = (state_q == EstadoActive);
        umbral_alto_out = umbral_alto_q;
        umbral_bajo_out = umbral_bajo_q;
        error_fifo      = error_fifo_q;
    end

endmodule
